// File: rtl/pcs_pkg.sv
// Shared constants, alignment-marker tables and the BIP3 parity function for the BASE-R PCS lanes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcs_pkg;

    localparam int         PCS_BLOCK_W       = 66;
    // Sync header values, written as block bits [1:0]. Bit 0 is transmitted first.
    localparam logic [1:0] SYNC_CTRL         = 2'b01;
    localparam logic [1:0] SYNC_DATA         = 2'b10;
    localparam int         AM_PERIOD_DEFAULT = 16383;

    // Packs one marker as {M2, M1, M0}, so M0 lands in the lowest payload byte.
    function automatic logic [23:0] am_pack(input logic [7:0] m0, input logic [7:0] m1,
                                            input logic [7:0] m2);
        return {m2, m1, m0};
    endfunction

    // Marker bytes M0..M2 for one lane. lane_n selects the 4-lane (40G)
    // or the 20-lane (100G) table. An unknown lane returns zero.
    function automatic logic [23:0] am_marker(input int lane_n, input int lane);
        logic [23:0] r;
        r = '0;
        if (lane_n == 20) begin
            case (lane)
                0:  r = am_pack(8'hC1, 8'h68, 8'h21);
                1:  r = am_pack(8'h9D, 8'h71, 8'h8E);
                2:  r = am_pack(8'h59, 8'h4B, 8'hE8);
                3:  r = am_pack(8'h4D, 8'h95, 8'h7B);
                4:  r = am_pack(8'hF5, 8'h07, 8'h09);
                5:  r = am_pack(8'hDD, 8'h14, 8'hC2);
                6:  r = am_pack(8'h9A, 8'h4A, 8'h26);
                7:  r = am_pack(8'h7B, 8'h45, 8'h66);
                8:  r = am_pack(8'hA0, 8'h24, 8'h76);
                9:  r = am_pack(8'h68, 8'hC9, 8'hFB);
                10: r = am_pack(8'hFD, 8'h6C, 8'h99);
                11: r = am_pack(8'hB9, 8'h91, 8'h55);
                12: r = am_pack(8'h5C, 8'hB9, 8'hB2);
                13: r = am_pack(8'h1A, 8'hF8, 8'hBD);
                14: r = am_pack(8'h83, 8'hC7, 8'hCA);
                15: r = am_pack(8'h35, 8'h36, 8'hCD);
                16: r = am_pack(8'hC4, 8'h31, 8'h4C);
                17: r = am_pack(8'hAD, 8'hD6, 8'hB7);
                18: r = am_pack(8'h5F, 8'h66, 8'h2A);
                19: r = am_pack(8'hC0, 8'hF0, 8'hE5);
                default: r = '0;
            endcase
        end else begin
            case (lane)
                0: r = am_pack(8'h90, 8'h76, 8'h47);
                1: r = am_pack(8'hF0, 8'hC4, 8'hE6);
                2: r = am_pack(8'hC5, 8'h65, 8'h9B);
                3: r = am_pack(8'hA2, 8'h79, 8'h3D);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // BIP3 bit k is the XOR of the eight payload bits that share column k
    // (block bits k+2, k+10, ...). Sync bits 0 and 1 also fold into parity
    // bits 3 and 4.
    function automatic logic [7:0] bip3_fn(input logic [PCS_BLOCK_W-1:0] blk);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 8; j++) begin
            r = r ^ blk[2 + 8*j +: 8];
        end
        r[3] = r[3] ^ blk[0];
        r[4] = r[4] ^ blk[1];
        return r;
    endfunction

endpackage

// File: rtl/pcs_bip_acc.sv
// Per-lane BIP3 accumulator over every block emitted on the lane.
// Latency: bip3 is the registered running parity. It reflects blocks emitted before the current edge.
// Backpressure: none. It takes one block on every clock edge after reset release.
// Ports: clk, nreset (async active-low), block (block as transmitted this cycle),
//        am_slot (this block is an AM), bip3 (parity since and including the last AM).
module pcs_bip_acc
    import pcs_pkg::*;
#(
    parameter int BLOCK_W = PCS_BLOCK_W
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [BLOCK_W-1:0] block,
    input  logic               am_slot,
    output logic [7:0]         bip3
);

    logic [7:0] r_acc;
    logic [7:0] w_blk_bip;

    assign w_blk_bip = bip3_fn(block);

    // On an AM slot, the AM already carries the old accumulator value in its BIP
    // fields. The new parity window therefore starts with the AM itself.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc <= 8'h00;
        end else if (am_slot) begin
            r_acc <= w_blk_bip;
        end else begin
            r_acc <= r_acc ^ w_blk_bip;
        end
    end

    assign bip3 = r_acc;

endmodule

// File: rtl/pcs_am_insert.sv
// Inserts one alignment marker into all PCS lanes every AM_PERIOD data blocks.
// Latency: 1 cycle from data_i to data_o. The first block after reset release is an AM.
// Backpressure: ready_o drops for the AM slot, and upstream holds data_i until ready_o returns.
// Ports: clk, nreset (async active-low), data_i (lane i at [i*BLOCK_W +: BLOCK_W]),
//        ready_o (data_i consumed at this edge), data_o (registered blocks),
//        block_v_o (data_o valid), am_v_o (data_o is an AM on every lane).
module pcs_am_insert
    import pcs_pkg::*;
#(
    parameter int LANE_N    = 4,
    parameter int BLOCK_W   = PCS_BLOCK_W,
    parameter int AM_PERIOD = AM_PERIOD_DEFAULT
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [LANE_N*BLOCK_W-1:0] data_i,
    output logic                      ready_o,
    output logic [LANE_N*BLOCK_W-1:0] data_o,
    output logic                      block_v_o,
    output logic                      am_v_o
);

    localparam int CNT_W = $clog2(AM_PERIOD + 1);

    logic [CNT_W-1:0]          r_cnt;
    logic                      w_am_slot;
    logic [LANE_N*BLOCK_W-1:0] w_tx;
    logic [LANE_N*BLOCK_W-1:0] r_data;
    logic                      r_block_v;
    logic                      r_am_v;

    // Reset parks the counter on the AM slot, so the first emitted block is a marker.
    assign w_am_slot = (r_cnt == CNT_W'(AM_PERIOD));
    assign ready_o   = ~w_am_slot;

    for (genvar g = 0; g < LANE_N; g++) begin : g_lane
        localparam logic [23:0] M_LANE = am_marker(LANE_N, g);

        logic [7:0]         w_bip3;
        logic [BLOCK_W-1:0] w_am;

        // M4..M6 and BIP7 are the bitwise complements of M0..M2 and BIP3.
        assign w_am = {~w_bip3, ~M_LANE, w_bip3, M_LANE, SYNC_CTRL};

        assign w_tx[g*BLOCK_W +: BLOCK_W] = w_am_slot ? w_am : data_i[g*BLOCK_W +: BLOCK_W];

        // The accumulator sees exactly what goes out on the lane, including the
        // AM with its BIP fields filled in.
        pcs_bip_acc #(
            .BLOCK_W (BLOCK_W)
        ) u_bip_acc (
            .clk     (clk),
            .nreset  (nreset),
            .block   (w_tx[g*BLOCK_W +: BLOCK_W]),
            .am_slot (w_am_slot),
            .bip3    (w_bip3)
        );
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt     <= CNT_W'(AM_PERIOD);
            r_data    <= '0;
            r_block_v <= 1'b0;
            r_am_v    <= 1'b0;
        end else begin
            r_block_v <= 1'b1;
            r_data    <= w_tx;
            r_am_v    <= w_am_slot;
            r_cnt     <= w_am_slot ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign data_o    = r_data;
    assign block_v_o = r_block_v;
    assign am_v_o    = r_am_v;

endmodule

// File: tb/tb_pcs_am_insert.sv
// Scoreboard bench for pcs_am_insert: a 4-lane short-period instance, a 20-lane full-period instance,
// and a standalone pcs_bip_acc.
// Latency: expected blocks are pushed before each edge and popped 1 ns after it.
// Backpressure: data held while ready_o is low, advanced only when consumed.
module tb_pcs_am_insert;

    localparam int NA = 4;
    localparam int PA = 4;
    localparam int NB = 20;
    localparam int PB = 16383;
    localparam int W  = 66;

    localparam logic [23:0] T40 [4] = '{24'h907647, 24'hF0C4E6, 24'hC5659B, 24'hA2793D};
    localparam logic [23:0] T100 [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              nreset_a = 1'b1;
    logic              nreset_b = 1'b1;
    logic              acc_nreset = 1'b1;
    logic [NA*W-1:0]   data_a_i = '0;
    logic [NA*W-1:0]   data_a_o;
    logic              ready_a, bv_a, am_a;
    logic [NB*W-1:0]   data_b_i = '0;
    logic [NB*W-1:0]   data_b_o;
    logic              ready_b, bv_b, am_b;
    logic [W-1:0]      acc_blk = '0;
    logic              acc_am = 1'b0;
    logic [7:0]        acc_bip;

    pcs_am_insert #(.LANE_N(NA), .BLOCK_W(W), .AM_PERIOD(PA)) u_dut_a (
        .clk(clk), .nreset(nreset_a), .data_i(data_a_i), .ready_o(ready_a),
        .data_o(data_a_o), .block_v_o(bv_a), .am_v_o(am_a));

    pcs_am_insert #(.LANE_N(NB), .BLOCK_W(W), .AM_PERIOD(PB)) u_dut_b (
        .clk(clk), .nreset(nreset_b), .data_i(data_b_i), .ready_o(ready_b),
        .data_o(data_b_o), .block_v_o(bv_b), .am_v_o(am_b));

    pcs_bip_acc #(.BLOCK_W(W)) u_acc (
        .clk(clk), .nreset(acc_nreset), .block(acc_blk), .am_slot(acc_am), .bip3(acc_bip));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NB*W-1:0] dat;
        logic            am;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         m_cnt [2];
    logic [7:0] m_acc [2][NB];

    function automatic logic [7:0] ref_bip(input logic [W-1:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 2; i < W; i++) r[(i-2) % 8] = r[(i-2) % 8] ^ b[i];
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    function automatic logic [W-1:0] ref_am(input int nl, input int lane, input logic [7:0] bip);
        logic [23:0] m;
        if (nl == NA) m = T40[lane];
        else          m = T100[lane];
        // m holds M0 in [23:16], M1 in [15:8] and M2 in [7:0].
        return {~bip, ~m[7:0], ~m[15:8], ~m[23:16], bip, m[7:0], m[15:8], m[23:16], 2'b01};
    endfunction

    task automatic model_reset(input int d);
        m_cnt[d] = (d == 0) ? PA : PB;
        for (int l = 0; l < NB; l++) m_acc[d][l] = 8'h00;
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic model_push(input int d);
        int              nl;
        int              per;
        logic [NB*W-1:0] din;
        logic [W-1:0]    blk;
        logic            rdy;
        exp_t            e;
        nl  = (d == 0) ? NA : NB;
        per = (d == 0) ? PA : PB;
        din = '0;
        if (d == 0) begin
            din[NA*W-1:0] = data_a_i;
            rdy = ready_a;
        end else begin
            din = data_b_i;
            rdy = ready_b;
        end
        e.am  = (m_cnt[d] == per);
        e.dat = '0;
        n_tests++;
        if (rdy !== !e.am) begin
            n_fail++;
            $display("FAIL ready dut%0d cnt=%0d got=%b exp=%b", d, m_cnt[d], rdy, !e.am);
        end
        for (int l = 0; l < nl; l++) begin
            blk = e.am ? ref_am(nl, l, m_acc[d][l]) : din[l*W +: W];
            e.dat[l*W +: W] = blk;
            m_acc[d][l] = e.am ? ref_bip(blk) : (m_acc[d][l] ^ ref_bip(blk));
        end
        m_cnt[d] = e.am ? 0 : m_cnt[d] + 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check_pop(input int d);
        exp_t e;
        int   bad;
        n_tests++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("FAIL scoreboard_empty dut%0d got=empty exp=entry", d);
            return;
        end
        if (d == 0) begin
            e = q0.pop_front();
            if ({bv_a, am_a, data_a_o} !== {1'b1, e.am, e.dat[NA*W-1:0]}) begin
                n_fail++;
                $display("FAIL blk_a v=%b am=%b dat=%h exp v=1 am=%b dat=%h",
                         bv_a, am_a, data_a_o, e.am, e.dat[NA*W-1:0]);
            end
        end else begin
            e = q1.pop_front();
            bad = -1;
            for (int l = NB-1; l >= 0; l--)
                if (data_b_o[l*W +: W] !== e.dat[l*W +: W]) bad = l;
            if (bv_b !== 1'b1 || am_b !== e.am || bad >= 0) begin
                n_fail++;
                if (bad < 0) bad = 0;
                $display("FAIL blk_b v=%b am=%b exp_am=%b lane=%0d got=%h exp=%h",
                         bv_b, am_b, e.am, bad, data_b_o[bad*W +: W], e.dat[bad*W +: W]);
            end
        end
    endtask

    task automatic step(input int d);
        model_push(d);
        @(posedge clk);
        #1;
        check_pop(d);
    endtask

    task automatic reset_a();
        nreset_a = 1'b0;
        model_reset(0);
        @(posedge clk);
        @(negedge clk);
        nreset_a = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        nreset_a = 1'b0;
        nreset_b = 1'b0;
        acc_nreset = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (data_a_o !== '0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", data_a_o); end
        n_tests++;
        if (bv_a !== 1'b0) begin n_fail++; $display("FAIL rst_block_v got=%b exp=0", bv_a); end
        n_tests++;
        if (am_a !== 1'b0) begin n_fail++; $display("FAIL rst_am_v got=%b exp=0", am_a); end
        n_tests++;
        if (ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready_a); end
        n_tests++;
        if ({bv_b, am_b, ready_b} !== 3'b000 || data_b_o !== '0) begin
            n_fail++;
            $display("FAIL rst_big v=%b am=%b rdy=%b exp all 0", bv_b, am_b, ready_b);
        end
    endtask

    task automatic test_am_sequence();
        logic [63:0] pay;
        for (int l = 0; l < NA; l++) data_a_i[l*W +: W] = {32'hA5A5_0000 | 32'(l), 32'h1234_5678, 2'b10};
        @(negedge clk);
        nreset_a = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step(0);
            n_tests++;
            if (am_a !== (i % 5 == 0)) begin
                n_fail++;
                $display("FAIL am_pattern i=%0d got=%b exp=%b", i, am_a, (i % 5 == 0));
            end
            if (i == 0) begin
                pay = data_a_o[65:2];
                n_tests++;
                if (pay !== 64'hFFB8_896F_0047_7690 || data_a_o[1:0] !== 2'b01) begin
                    n_fail++;
                    $display("FAIL first_am_lane0 got=%h exp=ffb8896f00477690", pay);
                end
                pay = data_a_o[3*W+2 +: 64];
                n_tests++;
                if (pay !== 64'hFFC2_865D_003D_79A2) begin
                    n_fail++;
                    $display("FAIL first_am_lane3 got=%h exp=ffc2865d003d79a2", pay);
                end
            end
        end
    endtask

    task automatic test_tags();
        logic [31:0] tag;
        logic [31:0] exp_tag;
        logic        rdy;
        tag = 32'd0;
        exp_tag = 32'd0;
        reset_a();
        for (int l = 0; l < NA; l++) data_a_i[l*W +: W] = {tag, 24'(l), 8'h5A, 2'b10};
        for (int i = 0; i < 16; i++) begin
            rdy = ready_a;
            step(0);
            if (!am_a) begin
                n_tests++;
                if (data_a_o[34 +: 32] !== exp_tag || data_a_o[3*W+34 +: 32] !== exp_tag) begin
                    n_fail++;
                    $display("FAIL tag i=%0d got=%0d/%0d exp=%0d", i,
                             data_a_o[34 +: 32], data_a_o[3*W+34 +: 32], exp_tag);
                end
                exp_tag++;
            end
            if (rdy) begin
                tag++;
                for (int l = 0; l < NA; l++) data_a_i[l*W +: W] = {tag, 24'(l), 8'h5A, 2'b10};
            end
        end
        n_tests++;
        if (exp_tag !== 32'd12) begin
            n_fail++;
            $display("FAIL tag_count got=%0d exp=12", exp_tag);
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        for (int i = 0; i < 3; i++) step(0);
        #2;
        nreset_a = 1'b0;
        #1;
        n_tests++;
        if ({bv_a, am_a, ready_a} !== 3'b000 || data_a_o !== '0) begin
            n_fail++;
            $display("FAIL mid_reset v=%b am=%b rdy=%b dat=%h exp all 0", bv_a, am_a, ready_a, data_a_o);
        end
        model_reset(0);
        @(negedge clk);
        nreset_a = 1'b1;
        step(0);
        n_tests++;
        if (am_a !== 1'b1 || data_a_o[33:26] !== 8'h00 || data_a_o[65:58] !== 8'hFF) begin
            n_fail++;
            $display("FAIL mid_reset_am am=%b bip3=%h bip7=%h exp 1/00/ff",
                     am_a, data_a_o[33:26], data_a_o[65:58]);
        end
        for (int i = 0; i < 5; i++) step(0);
    endtask

    task automatic test_bip_acc();
        logic [W-1:0] blks [4];
        logic         ams  [4];
        logic [7:0]   exps [4];
        logic [7:0]   q_exp[$];
        logic [7:0]   e;
        blks[0] = '1;              ams[0] = 1'b1; exps[0] = 8'h18;
        blks[1] = W'(1) << 2;      ams[1] = 1'b1; exps[1] = 8'h01;
        blks[2] = W'(1);           ams[2] = 1'b1; exps[2] = 8'h08;
        blks[3] = '1;              ams[3] = 1'b0; exps[3] = 8'h10;
        @(negedge clk);
        acc_nreset = 1'b1;
        n_tests++;
        if (acc_bip !== 8'h00) begin n_fail++; $display("FAIL acc_reset got=%h exp=00", acc_bip); end
        for (int i = 0; i < 4; i++) begin
            acc_blk = blks[i];
            acc_am  = ams[i];
            q_exp.push_back(exps[i]);
            @(posedge clk);
            #1;
            e = q_exp.pop_front();
            n_tests++;
            if (acc_bip !== e) begin
                n_fail++;
                $display("FAIL bip_acc i=%0d got=%h exp=%h", i, acc_bip, e);
            end
        end
    endtask

    task automatic rand_b();
        for (int l = 0; l < NB; l++) data_b_i[l*W +: W] = {$urandom(), $urandom(), 2'b10};
    endtask

    task automatic test_golden_big();
        logic         rdy;
        logic [W-1:0] blk;
        int           n_am;
        n_am = 0;
        rand_b();
        @(negedge clk);
        nreset_b = 1'b1;
        for (int i = 0; i < 2*(PB+1) + 3; i++) begin
            rdy = ready_b;
            step(1);
            if (am_b) begin
                n_am++;
                for (int l = 0; l < NB; l++) begin
                    blk = data_b_o[l*W +: W];
                    n_tests++;
                    if (blk[65:58] !== ~blk[33:26]) begin
                        n_fail++;
                        $display("FAIL bip7 lane=%0d got=%h exp=%h", l, blk[65:58], ~blk[33:26]);
                    end
                end
            end
            if (rdy) rand_b();
        end
        n_tests++;
        if (n_am != 3) begin
            n_fail++;
            $display("FAIL big_am_count got=%0d exp=3", n_am);
        end
    endtask

    initial begin
        test_reset();
        test_am_sequence();
        test_tags();
        test_reset_mid();
        test_bip_acc();
        test_golden_big();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
